// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot column strobes, frame-level debounce, single-key press
// detection and a valid/ready key-code output. Define KEYPAD_REPEAT_EN for held-key auto-repeat.
module keypad_scan_ctrl #(
    parameter int unsigned ROWS        = 4,
    parameter int unsigned COLS        = 4,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned CODE_W      = $clog2(ROWS*COLS),
    parameter int unsigned REPEAT_DLY  = 50,
    parameter int unsigned REPEAT_RATE = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ROWS-1:0]   rows_in,
    output logic [COLS-1:0]   cols_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_multi,
    output logic              overflow
);
    localparam int unsigned NKEY   = ROWS*COLS;
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned CIDX_W = $clog2(COLS);
    localparam int unsigned ST_W   = $clog2(DEBOUNCE+1);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESSED = 2'd1, MULTI = 2'd2} state_t;

    logic [ROWS-1:0]   rows_s1_q, rows_s2_q;
    logic              en_q;
    logic [DIV_W-1:0]  div_q;
    logic [CIDX_W-1:0] col_idx_q, col_idx_d;
    logic [COLS-1:0]   cols_q, cols_d;
    logic [NKEY-1:0]   snap_q, snap_d, prev_q, deb_q, deb_d;
    logic [ST_W-1:0]   stable_q, stable_d;
    logic              div_end, frame_end;
    logic              deb_zero, deb_single;
    logic [CODE_W-1:0] code_d;
    state_t            state_q, state_d;
    logic              ev_d;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q, key_multi_q, overflow_q;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX+1);
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d, rep_cnt_inc;
    logic              rep_run_q, rep_run_d;
    logic [CODE_W-1:0] press_q, press_d;
`endif

    // Scan timing only runs once enable has been seen at an edge, so every dwell is full length.
    always_comb begin
        div_end   = en_q && (div_q == DIV_W'(SCAN_DIV-1));
        frame_end = div_end && (col_idx_q == CIDX_W'(COLS-1));
        col_idx_d = col_idx_q;
        if (div_end) col_idx_d = frame_end ? '0 : col_idx_q + CIDX_W'(1);
        cols_d = '0;
        for (int unsigned c = 0; c < COLS; c++) cols_d[c] = (col_idx_d == CIDX_W'(c));
        snap_d = snap_q;
        for (int unsigned c = 0; c < COLS; c++)
            if (div_end && col_idx_q == CIDX_W'(c)) snap_d[c*ROWS +: ROWS] = rows_s2_q;
        stable_d = stable_q;
        deb_d    = deb_q;
        if (frame_end) begin
            if (snap_d != prev_q)                    stable_d = ST_W'(1);
            else if (stable_q != ST_W'(DEBOUNCE))    stable_d = stable_q + ST_W'(1);
            if (stable_d == ST_W'(DEBOUNCE))         deb_d = snap_d;
        end
        deb_zero   = (deb_d == '0);
        deb_single = !deb_zero && ((deb_d & (deb_d - NKEY'(1))) == '0);
        code_d = '0;
        for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
                if (deb_d[c*ROWS + r]) code_d = CODE_W'(r*COLS + c);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_s1_q <= '0;
            rows_s2_q <= '0;
            en_q      <= 1'b0;
            div_q     <= '0;
            col_idx_q <= '0;
            cols_q    <= '0;
            snap_q    <= '0;
            prev_q    <= '0;
            deb_q     <= '0;
            stable_q  <= '0;
        end else begin
            rows_s1_q <= rows_in;
            rows_s2_q <= rows_s1_q;
            en_q      <= enable;
            if (!enable) begin
                div_q     <= '0;
                col_idx_q <= '0;
                cols_q    <= '0;
                snap_q    <= '0;
                prev_q    <= '0;
                deb_q     <= '0;
                stable_q  <= '0;
            end else begin
                if (en_q) div_q <= div_end ? '0 : div_q + DIV_W'(1);
                col_idx_q <= col_idx_d;
                cols_q    <= cols_d;
                snap_q    <= snap_d;
                if (frame_end) prev_q <= snap_d;
                stable_q  <= stable_d;
                deb_q     <= deb_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ev_d    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_run_d   = rep_run_q;
        press_d     = press_q;
        rep_cnt_inc = rep_cnt_q + REP_W'(1);
`endif
        if (!enable) begin
            state_d = IDLE;
        end else if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (deb_single) begin
                        state_d = PRESSED;
                        ev_d    = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        press_d = code_d;
`endif
                    end else if (!deb_zero) begin
                        state_d = MULTI;
                    end
                end
                PRESSED: begin
                    if (deb_zero)          state_d = IDLE;
                    else if (!deb_single)  state_d = MULTI;
`ifdef KEYPAD_REPEAT_EN
                    else if (code_d == press_q) begin
                        if (rep_cnt_inc == REP_W'(rep_run_q ? REPEAT_RATE : REPEAT_DLY)) begin
                            ev_d      = 1'b1;
                            rep_cnt_d = '0;
                            rep_run_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_inc;
                        end
                    end
`endif
                end
                MULTI:   if (deb_zero) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        if (state_d != PRESSED) begin
            rep_cnt_d = '0;
            rep_run_d = 1'b0;
        end
`endif
    end

    // An event collides with a pending key only if the consumer is not taking it this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_multi_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_run_q   <= 1'b0;
            press_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            key_multi_q <= (state_d == MULTI);
            if (ev_d) begin
                if (key_valid_q && !key_ready) begin
                    overflow_q <= 1'b1;
                end else begin
                    key_code_q  <= code_d;
                    key_valid_q <= 1'b1;
                end
            end else if (key_valid_q && key_ready) begin
                key_valid_q <= 1'b0;
            end
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
            rep_run_q <= rep_run_d;
            press_q   <= press_d;
`endif
        end
    end

    assign cols_out  = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_multi = key_multi_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl (4x4, 4-cycle dwell, 3-frame debounce) with a key-matrix model
// and a scoreboard of expected key codes consumed on each valid/ready transfer.
module tb_keypad_scan_ctrl;
    localparam int FRAME = 16;

    logic        clk = 1'b0;
    logic        reset, enable, key_ready;
    logic [3:0]  rows_in, cols_out, key_code;
    logic        key_valid, key_multi, overflow;
    logic [15:0] keys;

    // keys bit index is row*4+col, i.e. the key code
    always_comb begin
        rows_in = '0;
        for (int r = 0; r < 4; r++) rows_in[r] = |(cols_out & keys[r*4 +: 4]);
    end

    keypad_scan_ctrl #(.ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rows_in(rows_in), .cols_out(cols_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_multi(key_multi), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_xfer = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1) begin
            n_xfer++;
            if (exp_q.size() == 0) check("unexpected_event", {28'd0, key_code}, 32'hFFFF_FFFF);
            else                   check("key_code_xfer", {28'd0, key_code}, {28'd0, exp_q.pop_front()});
        end
    end

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic        ready;
        logic        push;
        logic [3:0]  code;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic        exp_multi;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int lat, x0;
        logic bad_idle;
        //            keys      frm rdy push code  vld  code  multi ovf
        tbl[0]  = '{16'h0008, 5, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b0};
        tbl[1]  = '{16'h0000, 5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0};
        tbl[2]  = '{16'h0020, 5, 1'b0, 1'b1, 4'd5, 1'b1, 4'd5, 1'b0, 1'b0};
        tbl[3]  = '{16'h0000, 5, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b0};
        tbl[4]  = '{16'h0040, 5, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 1'b1};
        tbl[5]  = '{16'h0040, 2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1};
        tbl[6]  = '{16'h0000, 5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1};
        tbl[7]  = '{16'h8001, 5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1};
        tbl[8]  = '{16'h0001, 5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1};
        tbl[9]  = '{16'h0000, 5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd5, 1'b0, 1'b1};
        tbl[10] = '{16'h0001, 5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1};
        tbl[11] = '{16'h0000, 5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1};

        reset = 1'b1; enable = 1'b0; key_ready = 1'b1; keys = '0;
        cyc(3);
        check("rst_cols", {28'd0, cols_out}, 32'd0);
        check("rst_code", {28'd0, key_code}, 32'd0);
        check("rst_valid", {31'd0, key_valid}, 32'd0);
        check("rst_multi", {31'd0, key_multi}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        reset = 1'b0; enable = 1'b1;
        bad_idle = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cyc(1);
            check($sformatf("scan_cols_c%0d", k), {28'd0, cols_out}, 32'd1 << (((k-1)/4) % 4));
            if (key_valid || key_multi || overflow || key_code != 4'd0) bad_idle = 1'b1;
        end
        check("scan_idle_outputs", {31'd0, bad_idle}, 32'd0);

        // single press of key 9, starting at a frame boundary
        cyc(8);
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        x0 = n_xfer;
        lat = 0;
        for (int i = 1; i <= 80 && lat == 0; i++) begin
            cyc(1);
            if (key_valid) lat = i;
        end
        n_cmp++;
        if (lat < 33 || lat > 51) begin
            n_bad++;
            $display("FAIL press_latency: actual=%0d cycles required=33..51", lat);
        end
        cyc(6*FRAME);
        check("hold_single_event", n_xfer - x0, 32'd1);
        check("hold_code", {28'd0, key_code}, 32'd9);
        check("hold_valid_low", {31'd0, key_valid}, 32'd0);
        keys = '0;
        cyc(5*FRAME);

        x0 = n_xfer;
        keys = 16'h0200;
        cyc(20);
        keys = '0;
        cyc(5*FRAME);
        check("glitch_no_event", n_xfer - x0, 32'd0);
        check("glitch_code", {28'd0, key_code}, 32'd9);

        for (int i = 0; i < 12; i++) begin
            keys = tbl[i].keys;
            key_ready = tbl[i].ready;
            if (tbl[i].push) exp_q.push_back(tbl[i].code);
            cyc(tbl[i].frames * FRAME);
            check($sformatf("step%0d_valid", i), {31'd0, key_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("step%0d_code", i), {28'd0, key_code}, {28'd0, tbl[i].exp_code});
            check($sformatf("step%0d_multi", i), {31'd0, key_multi}, {31'd0, tbl[i].exp_multi});
            check($sformatf("step%0d_ovf", i), {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
            if (tbl[i].ready) check($sformatf("step%0d_drain", i), exp_q.size(), 32'd0);
        end

        // disable part-way through debouncing key 10
        keys = 16'h0400;
        cyc(20);
        enable = 1'b0;
        cyc(1);
        check("dis_cols", {28'd0, cols_out}, 32'd0);
        cyc(5*FRAME);
        check("dis_valid", {31'd0, key_valid}, 32'd0);
        check("dis_code", {28'd0, key_code}, 32'd0);
        exp_q.push_back(4'd10);
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            check($sformatf("reen_cols_c%0d", k), {28'd0, cols_out}, 32'd1 << ((k-1)/4));
        end
        cyc(5*FRAME);
        check("reen_drain", exp_q.size(), 32'd0);
        check("reen_code", {28'd0, key_code}, 32'd10);
        keys = '0;
        cyc(5*FRAME);

        // reset while a key is waiting for the consumer
        key_ready = 1'b0;
        keys = 16'h1000;
        cyc(5*FRAME);
        check("pend_valid", {31'd0, key_valid}, 32'd1);
        check("pend_code", {28'd0, key_code}, 32'd12);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, key_valid}, 32'd0);
        check("arst_code", {28'd0, key_code}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        check("arst_cols", {28'd0, cols_out}, 32'd0);
        keys = '0;
        cyc(3);
        reset = 1'b0;
        key_ready = 1'b1;
        cyc(5*FRAME);
        check("post_rst_valid", {31'd0, key_valid}, 32'd0);
        check("post_rst_ovf", {31'd0, overflow}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
